audio_i2s_tx: RTL
=================

// Module: audio_i2s_tx
// PURPOSE
//  Sink end of the effects chain's 16-bit sample strobe interface (sample/valid, 1-cycle valid).
//  Holds the latest processed sample and serialises it to an external I2S DAC as mono
//  (same word on L and R), 64 BCLK per frame, 32 slots per channel.
//  Sample arrival and frame timing are decoupled: a one-word holding register absorbs jitter.
//  Under/overrun counters report rate mismatch.
// PARAMETERS
//  BCLK_HALF  18  system clocks per BCLK half-period (>=2); BCLK = f_clk/(2*BCLK_HALF)
// PORTS
//  clk               in   1   system clock, single clock domain
//  rst               in   1   asynchronous, active-high reset
//  sample_in         in   16  signed two's-complement sample
//  sample_in_valid   in   1   1-cycle strobe; sample_in valid this cycle
//  i2s_bclk          out  1   bit clock (registered)
//  i2s_lrck          out  1   word select: 0 = left, 1 = right (registered)
//  i2s_sdata         out  1   serial data, MSB first (registered)
//  frame_start       out  1   1-cycle strobe when a new frame word is loaded
//  underrun_count    out  16  frames loaded with no new sample since last load (saturating)
//  overrun_count     out  16  samples overwritten before being framed (saturating)
// BEHAVIOUR
//  Reset (async): all outputs 0. div_cnt=0, slot=0, hold=0, pending=0, frame_word=0.
//  Divider: div_cnt counts 0..BCLK_HALF-1; at terminal count it wraps and i2s_bclk toggles.
//  Falling edge: cycle where i2s_bclk registers 1->0. Only there does slot (6b, 0..63) advance (mod 64).
//  i2s_lrck, i2s_sdata update in that same cycle. They are stable across BCLK rising edge.
//  Slot map for new slot s: i2s_lrck = s[5]; p = s[4:0]:
//    p in 1..16  -> i2s_sdata = frame_word[16-p]  (MSB at p=1: standard I2S one-bit delay)
//    p = 0 or 17..31 -> i2s_sdata = 0.
//  Frame load: on the falling edge where slot wraps 63->0:
//    frame_word <= hold; frame_start = 1 for that cycle only.
//    if !pending, underrun_count++ (sat at 16'hFFFF); pending <= 0.
//  Input: on sample_in_valid, hold <= sample_in; pending <= 1.
//    If pending was already 1 and this is not a frame-load cycle, overrun_count++ (sat).
//  Simultaneous valid + frame load: frame takes the OLD hold, and pending is cleared then set
//    (the new sample waits for the next frame). No overrun; underrun judged on the old pending.
//  Underrun: previous hold re-sent (sample repeat), never zeros.
//  Latency: accepted sample -> MSB on pin at slot 1 after next frame load.
//    Worst case ~64*2*BCLK_HALF + 2*BCLK_HALF cycles.
//  After reset: first frame load occurs 64*2*BCLK_HALF cycles after rst deasserts.
//    Frame before it transmits zeros.
//  Counters only reset via rst; no clear input.
// TESTING
//  BCLK_HALF=2, one strobe 16'hA5C3 before first load
//    -> after load, L slots 1..16 = 1010_0101_1100_0011, 17..31 = 0, R identical.
//  Period checks: i2s_lrck period = 256 clk; i2s_bclk period = 4 clk.
//    i2s_sdata/i2s_lrck change only in falling-edge cycles.
//  No strobes for 3 frames after 16'h8001
//    -> 16'h8001 re-sent each frame; underrun_count = 3; frame_start pulses once per 256 clk.
//  Strobes 16'h1111 then 16'h2222 within one frame
//    -> next frame sends 16'h2222; overrun_count = 1; underrun_count unchanged.
//  Strobe 16'h7FFF in exact frame_start cycle
//    -> that frame sends previous word; next frame sends 16'h7FFF with no underrun.
//  Assert rst mid-right-channel
//    -> all outputs 0 same cycle (async); after release, restart at slot 0 with zero word and counters 0.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// Mono I2S transmitter: takes 16-bit sample strobes into a one-word holding register and
// serialises the latest word on both channels, 64 BCLK per frame, with under/overrun counters.
module audio_i2s_tx #(
    parameter int BCLK_HALF = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_in,
    input  logic        sample_in_valid,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_sdata,
    output logic        frame_start,
    output logic [15:0] underrun_count,
    output logic [15:0] overrun_count
);

    localparam int DIV_W = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       slot;
    logic [5:0]       slot_nxt;
    logic [4:0]       pos;
    logic [15:0]      hold;
    logic [15:0]      frame_word;
    logic             pending;
    logic             tc;
    logic             fall;
    logic             load;
    logic             sdata_nxt;

    assign tc       = (div_cnt == DIV_W'(BCLK_HALF - 1));
    assign fall     = tc & i2s_bclk;
    assign slot_nxt = slot + 6'd1;
    assign pos      = slot_nxt[4:0];
    assign load     = fall & (slot == 6'd63);

    // One-bit I2S delay: MSB lands in position 1 of each 32-slot half.
    // At the load edge the new slot is 0, so the stale frame_word is never shown.
    always_comb begin
        sdata_nxt = 1'b0;
        if (pos >= 5'd1 && pos <= 5'd16)
            sdata_nxt = frame_word[4'(5'd16 - pos)];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (tc) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot      <= '0;
            i2s_lrck  <= 1'b0;
            i2s_sdata <= 1'b0;
        end else if (fall) begin
            slot      <= slot_nxt;
            i2s_lrck  <= slot_nxt[5];
            i2s_sdata <= sdata_nxt;
        end
    end

    // A strobe coinciding with a load waits for the next frame: frame takes the old hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold           <= '0;
            pending        <= 1'b0;
            frame_word     <= '0;
            frame_start    <= 1'b0;
            underrun_count <= '0;
            overrun_count  <= '0;
        end else begin
            frame_start <= load;
            if (load) begin
                frame_word <= hold;
                if (!pending && underrun_count != 16'hFFFF)
                    underrun_count <= underrun_count + 16'd1;
            end
            if (sample_in_valid) begin
                hold <= sample_in;
                if (pending && !load && overrun_count != 16'hFFFF)
                    overrun_count <= overrun_count + 16'd1;
            end
            if (sample_in_valid)
                pending <= 1'b1;
            else if (load)
                pending <= 1'b0;
        end
    end

endmodule
